// File: rtl/adc_patgen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_patgen_pkg
// Description : Shared types, constants and helpers for the ADC pattern
//               generator (pattern modes, FSM states, PRBS15 polynomial,
//               checkerboard word builder).
//               PRBS15 support is built only when ADC_PATGEN_PRBS_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_patgen_pkg;

  // Pattern select codes; 5..7 are reserved and produce all-zero samples.
  typedef enum logic [2:0] {
    MODE_RAMP_UP   = 3'd0,
    MODE_RAMP_DOWN = 3'd1,
    MODE_CHECKER   = 3'd2,
    MODE_FIXED     = 3'd3,
    MODE_PRBS      = 3'd4
  } mode_e;

  // Generator control states.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // PRBS15: x^15 + x^14 + 1, taps on state bits 14 and 13.
  localparam int unsigned       PRBS_W    = 15;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 15'h6000;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 15'h7FFF;

  // Checkerboard word of the requested width: phase 0 gives ...0101,
  // phase 1 gives ...1010. Bits at and above width are cleared.
  function automatic logic [15:0] checker_word(input int unsigned width,
                                               input logic        phase);
    logic [15:0] w;
    w = phase ? 16'hAAAA : 16'h5555;
    for (int i = 0; i < 16; i++) begin
      if (i >= int'(width)) begin
        w[i] = 1'b0;
      end
    end
    return w;
  endfunction

  // One Fibonacci LFSR step: shift left, feedback is the XOR of the taps.
  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], ^(s & PRBS_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_patgen_lane.sv
`default_nettype none
// ============================================================================
// Module      : adc_patgen_lane
// Description : Single-channel sample generator. Holds the ramp accumulator,
//               checkerboard phase and (optionally) a PRBS15 LFSR, selects
//               the pattern, applies odd-channel inversion and produces the
//               overrange flag for the emitted value.
//               Macro ADC_PATGEN_PRBS_EN builds the per-lane LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_patgen_lane
  import adc_patgen_pkg::*;
#(
  parameter int unsigned       DATA_W    = 14,
  parameter int unsigned       CH        = 0,
  parameter logic [DATA_W-1:0] CH_OFFSET = 'h100,
  parameter bit                INV_ODD   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              adv,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] fixed_val,
  input  logic [DATA_W-1:0] or_thresh,
  output logic [DATA_W-1:0] sample,
  output logic              or_flag
);

  // Ramp seed is this channel's offset, wrapped to the sample width.
  localparam logic [DATA_W-1:0] RAMP_SEED = DATA_W'(CH * CH_OFFSET);
  localparam bit                INVERT    = INV_ODD && ((CH % 2) == 1);

  logic [DATA_W-1:0] r_ramp;
  logic              r_phase;
  logic [DATA_W-1:0] w_chk;
  logic [DATA_W-1:0] w_gen;

  assign w_chk = DATA_W'(checker_word(DATA_W, r_phase));

  // Ramp accumulator and checker phase: reseed on load, step on each sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ramp  <= RAMP_SEED;
      r_phase <= 1'b0;
    end else if (load) begin
      r_ramp  <= RAMP_SEED;
      r_phase <= 1'b0;
    end else if (adv) begin
      if (mode == MODE_RAMP_DOWN) begin
        r_ramp <= r_ramp - step;
      end else begin
        r_ramp <= r_ramp + step;
      end
      r_phase <= ~r_phase;
    end
  end

`ifdef ADC_PATGEN_PRBS_EN
  localparam logic [PRBS_W-1:0] LFSR_SEED = PRBS_SEED ^ PRBS_W'(CH);

  logic [PRBS_W-1:0] r_lfsr;
  logic [DATA_W-1:0] w_prbs;

  // Low bits of the LFSR state, zero-extended when the sample is wider.
  assign w_prbs = DATA_W'(r_lfsr);

  // PRBS15 state: per-channel seed on load, one step per issued sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else if (load) begin
      r_lfsr <= LFSR_SEED;
    end else if (adv) begin
      r_lfsr <= prbs_next(r_lfsr);
    end
  end
`endif

  // Pattern select on the pre-advance generator state.
  always_comb begin
    w_gen = '0;
    case (mode)
      MODE_RAMP_UP,
      MODE_RAMP_DOWN: w_gen = r_ramp;
      MODE_CHECKER:   w_gen = w_chk;
      MODE_FIXED:     w_gen = fixed_val;
`ifdef ADC_PATGEN_PRBS_EN
      MODE_PRBS:      w_gen = w_prbs;
`endif
      default:        w_gen = '0;
    endcase
  end

  // Overrange compares against the value actually emitted (after inversion).
  assign sample  = INVERT ? ~w_gen : w_gen;
  assign or_flag = (sample >= or_thresh);

endmodule
`default_nettype wire

// File: rtl/adc_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_pattern_gen
// Description : N-channel parallel ADC data-pattern generator. Start/stop
//               burst control FSM, sample counter and registered outputs;
//               one adc_patgen_lane per channel.
//               Macro ADC_PATGEN_PRBS_EN enables PRBS15 mode (mode 4);
//               without it mode 4 behaves as a reserved mode.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_pattern_gen
  import adc_patgen_pkg::*;
#(
  parameter int unsigned       NUM_CH    = 2,
  parameter int unsigned       DATA_W    = 14,
  parameter int unsigned       CNT_W     = 16,
  parameter logic [DATA_W-1:0] CH_OFFSET = 'h100,
  parameter bit                INV_ODD   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     en,
  input  logic [2:0]               mode,
  input  logic [DATA_W-1:0]        step,
  input  logic [DATA_W-1:0]        fixed_val,
  input  logic [DATA_W-1:0]        or_thresh,
  input  logic [CNT_W-1:0]         burst_len,
  output logic                     busy,
  output logic                     done,
  output logic                     dout_valid,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic [NUM_CH-1:0]        dout_or,
  output logic [CNT_W-1:0]         sample_cnt
);

  state_e r_state;
  state_e w_state_next;

  logic [2:0]        r_mode;
  logic [DATA_W-1:0] r_step;
  logic [DATA_W-1:0] r_fixed;
  logic [DATA_W-1:0] r_thresh;
  logic [CNT_W-1:0]  r_burst_len;
  logic [CNT_W-1:0]  r_cnt;

  logic                     r_dout_valid;
  logic                     r_done;
  logic [NUM_CH*DATA_W-1:0] r_dout;
  logic [NUM_CH-1:0]        r_dout_or;

  logic                     w_load;
  logic                     w_issue;
  logic                     w_last;
  logic [CNT_W-1:0]         w_cnt_inc;
  logic [NUM_CH*DATA_W-1:0] w_sample;
  logic [NUM_CH-1:0]        w_or;

  // Start is only honoured from IDLE and loses to a simultaneous stop.
  assign w_load    = (r_state == ST_IDLE) && start && !stop;
  // A sample issued in the stop cycle still goes out.
  assign w_issue   = (r_state == ST_RUN) && en;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // Final sample of a finite burst: the count reaches burst_len with it.
  assign w_last    = w_issue && (r_burst_len != '0) && (w_cnt_inc == r_burst_len);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: stop aborts from anywhere, bursts end on the last sample.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop || w_last) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Burst configuration snapshot taken when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode      <= '0;
      r_step      <= '0;
      r_fixed     <= '0;
      r_thresh    <= '0;
      r_burst_len <= '0;
    end else if (w_load) begin
      r_mode      <= mode;
      r_step      <= step;
      r_fixed     <= fixed_val;
      r_thresh    <= or_thresh;
      r_burst_len <= burst_len;
    end
  end

  // Issued-sample counter; wraps naturally in continuous mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // Per-channel generators, channel 0 in the LSBs.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    adc_patgen_lane #(
      .DATA_W    (DATA_W),
      .CH        (g),
      .CH_OFFSET (CH_OFFSET),
      .INV_ODD   (INV_ODD)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .adv       (w_issue),
      .mode      (r_mode),
      .step      (r_step),
      .fixed_val (r_fixed),
      .or_thresh (r_thresh),
      .sample    (w_sample[g*DATA_W +: DATA_W]),
      .or_flag   (w_or[g])
    );
  end

  // Output registers: data holds between issued samples, strobes are 1-cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
      r_dout       <= '0;
      r_dout_or    <= '0;
    end else begin
      r_dout_valid <= w_issue;
      r_done       <= w_last && !stop;
      if (w_issue) begin
        r_dout    <= w_sample;
        r_dout_or <= w_or;
      end
    end
  end

  assign busy       = (r_state == ST_RUN);
  assign done       = r_done;
  assign dout_valid = r_dout_valid;
  assign dout       = r_dout;
  assign dout_or    = r_dout_or;
  assign sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_pattern_gen
// Description : Scoreboard bench for adc_pattern_gen (2 channels, 14-bit).
//               Expected samples are queued with each stimulus; a negedge
//               monitor pops and compares whenever dout_valid is high.
//               Mode 4 expectations follow ADC_PATGEN_PRBS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_pattern_gen;

  localparam int NCH = 2;
  localparam int DW  = 14;
  localparam int CW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              en;
  logic [2:0]        mode;
  logic [DW-1:0]     step;
  logic [DW-1:0]     fixed_val;
  logic [DW-1:0]     or_thresh;
  logic [CW-1:0]     burst_len;
  logic              busy;
  logic              done;
  logic              dout_valid;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    dout_or;
  logic [CW-1:0]     sample_cnt;

  typedef struct packed {
    logic [NCH*DW-1:0] dout;
    logic [NCH-1:0]    dor;
    logic              done;
    logic              busy;
    logic [CW-1:0]     cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic [4:0] en_seq = 5'b10101;

  always #5 clk = ~clk;

  adc_pattern_gen #(
    .NUM_CH    (NCH),
    .DATA_W    (DW),
    .CNT_W     (CW),
    .CH_OFFSET (14'h100),
    .INV_ODD   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .mode       (mode),
    .step       (step),
    .fixed_val  (fixed_val),
    .or_thresh  (or_thresh),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_or    (dout_or),
    .sample_cnt (sample_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] ch0, input logic [DW-1:0] ch1,
                      input logic [1:0] dor, input logic dn, input logic bsy,
                      input logic [CW-1:0] cnt);
    exp_t e;
    e.dout = {ch1, ch0};
    e.dor  = dor;
    e.done = dn;
    e.busy = bsy;
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic do_start(input logic [2:0] m, input logic [DW-1:0] st,
                          input logic [DW-1:0] fv, input logic [DW-1:0] th,
                          input logic [CW-1:0] bl);
    @(posedge clk); #1;
    mode = m; step = st; fixed_val = fv; or_thresh = th; burst_len = bl;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!busy) break;
    end
    check({name, "_idle"}, busy, 0);
    check({name, "_drain"}, q.size(), 0);
  endtask

  // Monitor: every valid output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (dout_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", dout_valid, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dout", dout, e.dout);
        check("dout_or", dout_or, e.dor);
        check("done", done, e.done);
        check("busy_with_sample", busy, e.busy);
        check("sample_cnt", sample_cnt, e.cnt);
      end
    end else if (done) begin
      check("done_without_valid", done, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1;
    mode = '0; step = '0; fixed_val = '0; or_thresh = '0; burst_len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", dout_valid, 0);
    check("rst_dout", dout, 0);
    check("rst_or", dout_or, 0);
    check("rst_cnt", sample_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Ramp up, step 1, burst 4; inputs scrambled after start to prove latching.
    push(14'h0000, 14'h3EFF, 2'b10, 1'b0, 1'b1, 16'd1);
    push(14'h0001, 14'h3EFE, 2'b10, 1'b0, 1'b1, 16'd2);
    push(14'h0002, 14'h3EFD, 2'b10, 1'b0, 1'b1, 16'd3);
    push(14'h0003, 14'h3EFC, 2'b10, 1'b1, 1'b0, 16'd4);
    do_start(3'd0, 14'd1, 14'd0, 14'h2000, 16'd4);
    mode = 3'd2; step = 14'h55; or_thresh = '0; burst_len = '0;
    @(negedge clk);
    check("busy_after_start", busy, 1);
    check("first_latency", dout_valid, 0);
    wait_idle("ramp4");

    // Ramp wrap with step 0x1000; a start pulse mid-burst must be ignored.
    push(14'h0000, 14'h3EFF, 2'b00, 1'b0, 1'b1, 16'd1);
    push(14'h1000, 14'h2EFF, 2'b00, 1'b0, 1'b1, 16'd2);
    push(14'h2000, 14'h1EFF, 2'b00, 1'b0, 1'b1, 16'd3);
    push(14'h3000, 14'h0EFF, 2'b00, 1'b0, 1'b1, 16'd4);
    push(14'h0000, 14'h3EFF, 2'b00, 1'b0, 1'b1, 16'd5);
    push(14'h1000, 14'h2EFF, 2'b00, 1'b1, 1'b0, 16'd6);
    do_start(3'd0, 14'h1000, 14'd0, 14'h3FFF, 16'd6);
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("wrap");

    // Ramp down step 2, burst 3, enable pattern 1,0,1,0,1.
    push(14'h0000, 14'h3EFF, 2'b00, 1'b0, 1'b1, 16'd1);
    push(14'h3FFE, 14'h3F01, 2'b11, 1'b0, 1'b1, 16'd2);
    push(14'h3FFC, 14'h3F03, 2'b11, 1'b1, 1'b0, 16'd3);
    do_start(3'd1, 14'd2, 14'd0, 14'h3F00, 16'd3);
    for (int k = 0; k < 5; k++) begin
      en = en_seq[k];
      @(negedge clk);
      check("en_gap_valid", dout_valid, (k == 0) ? 1'b0 : en_seq[k-1]);
      @(posedge clk); #1;
    end
    en = 1'b1;
    wait_idle("en_gap");

    // Fixed 0x3000 against threshold 0x2FFF; channel 1 sees 0x0FFF.
    push(14'h3000, 14'h0FFF, 2'b01, 1'b0, 1'b1, 16'd1);
    push(14'h3000, 14'h0FFF, 2'b01, 1'b1, 1'b0, 16'd2);
    do_start(3'd3, 14'd0, 14'h3000, 14'h2FFF, 16'd2);
    wait_idle("fixed");

    // Continuous checkerboard, stopped during the fifth sample.
    push(14'h1555, 14'h2AAA, 2'b10, 1'b0, 1'b1, 16'd1);
    push(14'h2AAA, 14'h1555, 2'b01, 1'b0, 1'b1, 16'd2);
    push(14'h1555, 14'h2AAA, 2'b10, 1'b0, 1'b1, 16'd3);
    push(14'h2AAA, 14'h1555, 2'b01, 1'b0, 1'b1, 16'd4);
    push(14'h1555, 14'h2AAA, 2'b10, 1'b0, 1'b0, 16'd5);
    do_start(3'd2, 14'd0, 14'd0, 14'h2000, 16'd0);
    repeat (4) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("after_stop_valid", dout_valid, 0);
      check("after_stop_busy", busy, 0);
    end
    check("stop_drain", q.size(), 0);

    // start and stop together in IDLE: stop wins.
    @(posedge clk); #1 start = 1'b1; stop = 1'b1;
    @(posedge clk); #1 start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("start_stop_busy", busy, 0);
    @(negedge clk);
    check("start_stop_valid", dout_valid, 0);

    // Mode 4: PRBS15 when built, otherwise reserved (zero samples).
`ifdef ADC_PATGEN_PRBS_EN
    push(14'h3FFF, 14'h0001, 2'b11, 1'b0, 1'b1, 16'd1);
    push(14'h3FFE, 14'h0003, 2'b11, 1'b0, 1'b1, 16'd2);
    push(14'h3FFC, 14'h0007, 2'b11, 1'b1, 1'b0, 16'd3);
`else
    push(14'h0000, 14'h3FFF, 2'b10, 1'b0, 1'b1, 16'd1);
    push(14'h0000, 14'h3FFF, 2'b10, 1'b0, 1'b1, 16'd2);
    push(14'h0000, 14'h3FFF, 2'b10, 1'b1, 1'b0, 16'd3);
`endif
    do_start(3'd4, 14'd0, 14'd0, 14'h0001, 16'd3);
    wait_idle("mode4");

    // Asynchronous reset in the middle of a 10-sample burst.
    push(14'h0000, 14'h3EFF, 2'b10, 1'b0, 1'b1, 16'd1);
    push(14'h0001, 14'h3EFE, 2'b10, 1'b0, 1'b1, 16'd2);
    do_start(3'd0, 14'd1, 14'd0, 14'h2000, 16'd10);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_valid", dout_valid, 0);
    check("async_dout", dout, 0);
    check("async_or", dout_or, 0);
    check("async_cnt", sample_cnt, 0);
    check("async_drain", q.size(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Next start reseeds fully.
    push(14'h0000, 14'h3EFF, 2'b10, 1'b0, 1'b1, 16'd1);
    push(14'h0001, 14'h3EFE, 2'b10, 1'b1, 1'b0, 16'd2);
    do_start(3'd0, 14'd1, 14'd0, 14'h2000, 16'd2);
    wait_idle("reseed");

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
